xd_bus_rx: RTL and testbench

XD_BUS_RX -- requirements
Module: xd_bus_rx

---
 rtl/xd_pkg.sv | 5 +
 rtl/xd_sync_bit.sv | 17 +
 rtl/xd_bus_rx.sv | 69 ++++++
 tb/tb_xd_bus_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/xd_pkg.sv
// xd_pkg: shared constants and FSM state type for the xd bus receiver
package xd_pkg;
    localparam int SYNC_STAGES_MIN = 2;
    typedef enum logic {IDLE, HOLD} xd_rx_state_t;
endpackage

// File: rtl/xd_sync_bit.sv
// xd_sync_bit: multi-flop synchronizer for a single asynchronous bit
module xd_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    // shift the raw input straight into the first flop, nothing in front of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/xd_bus_rx.sv
// xd_bus_rx: toggle-handshake CDC receiver; optional parity check via XD_BUS_RX_PARITY_EN
module xd_bus_rx
    import xd_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_req_tgl,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_ack_tgl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef XD_BUS_RX_PARITY_EN
    ,
    input  logic             src_parity,
    output logic             err_parity
`endif
);
    if (SYNC_STAGES < SYNC_STAGES_MIN || WIDTH < 1) begin : g_bad_param
        $error("xd_bus_rx: SYNC_STAGES must be >= 2 and WIDTH >= 1");
    end
    xd_rx_state_t state, state_nxt;
    logic req_sync, req_seen, new_req, capture, accept;
    xd_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (src_req_tgl),
        .q     (req_sync)
    );
    // a pending toggle stays in the chain until IDLE compares it against req_seen
    assign new_req   = req_sync ^ req_seen;
    assign out_valid = (state == HOLD);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: capture only from IDLE, accept (and ack) only from HOLD
    always_comb begin
        capture   = (state == IDLE) && new_req;
        accept    = (state == HOLD) && out_ready;
        state_nxt = capture ? HOLD : accept ? IDLE : state;
    end
    // capture word and request level together; flip ack once per accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data    <= '0;
            req_seen    <= 1'b0;
            dst_ack_tgl <= 1'b0;
        end else begin
            if (capture) begin
                out_data <= src_data;
                req_seen <= req_sync;
            end
            if (accept) dst_ack_tgl <= ~dst_ack_tgl;
        end
    end
`ifdef XD_BUS_RX_PARITY_EN
    // parity error flag travels with the captured word and drops on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_parity <= 1'b0;
        else if (capture) err_parity <= ^src_data ^ src_parity;
        else if (accept) err_parity <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_xd_bus_rx.sv
// tb_xd_bus_rx: directed and randomized-stream checks of the toggle-handshake receiver
module tb_xd_bus_rx;
    logic clk = 0, clk_src = 0, rst_n = 0, src_req_tgl = 0, out_ready = 0;
    logic [7:0] src_data = 0;
    logic dst_ack_tgl, out_valid;
    logic [7:0] out_data;
`ifdef XD_BUS_RX_PARITY_EN
    logic src_parity = 0, err_parity;
`endif
    int total = 0, bad = 0;

    always #10 clk = ~clk;
    initial begin
        #7;
        forever #27 clk_src = ~clk_src;
    end

    xd_bus_rx #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_req_tgl (src_req_tgl),
        .src_data    (src_data),
        .dst_ack_tgl (dst_ack_tgl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef XD_BUS_RX_PARITY_EN
        ,
        .src_parity  (src_parity),
        .err_parity  (err_parity)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        src_data = d;
`ifdef XD_BUS_RX_PARITY_EN
        src_parity = ^d;
`endif
        src_req_tgl = ~src_req_tgl;
    endtask

    initial begin
        int exp_q[$];
        int rcv, acks, budget;
        logic ack_prev, r;
        // reset state
        cyc(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ack", dst_ack_tgl, 0);
        rst_n = 1;
        // single word: capture three edges after the toggle, ack one cycle later
        out_ready = 1;
        send(8'hA5);
        cyc(1);
        chk("lat_e1_valid", out_valid, 0);
        cyc(1);
        chk("lat_e2_valid", out_valid, 0);
        chk("idle_ready_no_ack", dst_ack_tgl, 0);
        cyc(1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_ack_pre", dst_ack_tgl, 0);
        cyc(1);
        chk("single_valid_off", out_valid, 0);
        chk("single_ack", dst_ack_tgl, 1);
        // backpressure for ten cycles
        out_ready = 0;
        send(8'h3C);
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 8'h3C);
            chk("bp_ack", dst_ack_tgl, 1);
            cyc(1);
        end
        out_ready = 1;
        cyc(1);
        chk("bp_ack_after", dst_ack_tgl, 0);
        chk("bp_valid_after", out_valid, 0);
        // pending toggle during HOLD is captured right after the handshake
        out_ready = 0;
        send(8'h11);
        cyc(3);
        chk("pend_w1_data", out_data, 8'h11);
        send(8'h22);
        cyc(4);
        chk("pend_w1_held", out_data, 8'h11);
        chk("pend_w1_valid", out_valid, 1);
        out_ready = 1;
        cyc(1);
        chk("pend_ack1", dst_ack_tgl, 1);
        chk("pend_idle", out_valid, 0);
        cyc(1);
        chk("pend_w2_valid", out_valid, 1);
        chk("pend_w2_data", out_data, 8'h22);
        cyc(1);
        chk("pend_ack2", dst_ack_tgl, 0);
        // two toggles during HOLD cancel out
        out_ready = 0;
        send(8'h33);
        cyc(3);
        chk("coll_valid", out_valid, 1);
        src_req_tgl = ~src_req_tgl;
        cyc(4);
        src_req_tgl = ~src_req_tgl;
        cyc(4);
        out_ready = 1;
        cyc(1);
        chk("coll_ack", dst_ack_tgl, 1);
        for (int i = 0; i < 5; i++) begin
            chk("coll_no_word", out_valid, 0);
            cyc(1);
        end
        chk("coll_ack_stable", dst_ack_tgl, 1);
        // asynchronous reset while holding a word
        out_ready = 0;
        send(8'h5A);
        cyc(3);
        chk("rh_valid", out_valid, 1);
        chk("rh_data", out_data, 8'h5A);
        #3 rst_n = 0;
        #1;
        chk("rh_valid_clr", out_valid, 0);
        chk("rh_data_clr", out_data, 0);
        chk("rh_ack_clr", dst_ack_tgl, 0);
        cyc(1);
        src_req_tgl = 0;
        rst_n = 1;
        cyc(2);
        chk("rh_after_valid", out_valid, 0);
`ifdef XD_BUS_RX_PARITY_EN
        out_ready = 0;
        src_data = 8'h01;
        src_parity = 0;
        src_req_tgl = ~src_req_tgl;
        cyc(3);
        chk("par_valid", out_valid, 1);
        chk("par_err", err_parity, 1);
        out_ready = 1;
        cyc(1);
        chk("par_err_clr", err_parity, 0);
        out_ready = 0;
        src_parity = 1;
        src_req_tgl = ~src_req_tgl;
        cyc(3);
        chk("par_valid2", out_valid, 1);
        chk("par_ok", err_parity, 0);
        out_ready = 1;
        cyc(1);
`endif
        // stream of 256 words from an unrelated sender clock with random consumer stalls
        rcv = 0;
        acks = 0;
        budget = 0;
        ack_prev = dst_ack_tgl;
        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    int n;
                    @(posedge clk_src);
                    repeat ($urandom_range(0, 2)) @(posedge clk_src);
                    exp_q.push_back(i);
                    send(8'(i));
                    n = 0;
                    while (dst_ack_tgl !== src_req_tgl && n < 400) begin
                        @(posedge clk_src);
                        n++;
                    end
                    if (n >= 400) begin
                        chk("stream_ack_timeout", 32'(n), 0);
                        break;
                    end
                end
            end
            begin
                while (rcv < 256 && budget < 40000) begin
                    @(negedge clk);
                    budget++;
                    if (dst_ack_tgl !== ack_prev) begin
                        acks++;
                        ack_prev = dst_ack_tgl;
                    end
                    r = 1'($urandom_range(0, 1));
                    if (out_valid && r) begin
                        if (exp_q.size() > 0) chk("stream_data", out_data, exp_q.pop_front());
                        else chk("stream_unexpected", out_data, 32'hFFFF_FFFF);
                        rcv++;
                    end
                    out_ready = r;
                end
                @(negedge clk);
                if (dst_ack_tgl !== ack_prev) acks++;
                out_ready = 0;
            end
        join
        cyc(2);
        chk("stream_rcv", rcv, 256);
        chk("stream_acks", acks, 256);
        chk("stream_final_ack", dst_ack_tgl, 0);
        chk("stream_left", exp_q.size(), 0);
        chk("stream_idle", out_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
